// File: rtl/mac2x2_accumulator_pkg.sv
// Shared definitions for the 2x2 multiply-accumulate block:
// FSM state encoding and the product width of the 2x2 multiplier.
package mac2x2_accumulator_pkg;

  // Job control states; encoding is fixed so external debug taps stay stable.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of a 2-bit x 2-bit unsigned product (max 3*3 = 9).
  localparam int PROD_W = 4;

endpackage : mac2x2_accumulator_pkg

// File: rtl/multiplier2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier.
module multiplier2x2
  import mac2x2_accumulator_pkg::*;
(
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  output logic [PROD_W-1:0] c
);

  // Operands are widened first so the product is formed at full width.
  assign c = {2'b00, a} * {2'b00, b};

endmodule : multiplier2x2

// File: rtl/mac2x2_accumulator.sv
// Saturating multiply-accumulate over a job of len operand pairs.
// A job is started in IDLE, consumes len (a, b) transfers in RUN and
// presents the sum in DONE until the consumer takes it.
module mac2x2_accumulator
  import mac2x2_accumulator_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic               ovf_reg, ovf_next;

  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               sum_carry;

  multiplier2x2 u_mult (
    .a (a),
    .b (b),
    .c (prod)
  );

  // One extra bit catches the carry out; any carry means the true sum
  // no longer fits and the result clamps to all ones.
  assign sum_wide  = {1'b0, acc_reg} + (ACC_W + 1)'(prod);
  assign sum_carry = sum_wide[ACC_W];
  assign sum_sat   = sum_carry ? '1 : sum_wide[ACC_W-1:0];

  // State and datapath registers; reset is asynchronous so outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      ovf_reg       <= ovf_next;
    end
  end

  // Next-state and datapath update; everything holds unless a rule below fires.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    ovf_next       = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (len != '0) begin
            remaining_next = len;
            state_next     = RUN;
          end else begin
            remaining_next = '0;
            state_next     = DONE;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          acc_next       = sum_sat;
          ovf_next       = ovf_reg | sum_carry;
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Returning to IDLE here means a start seen on this same edge is
        // dropped; the next job can only begin one cycle later.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags decode straight from the state register, so there is
  // no combinational path from the input side to out_valid.
  assign in_ready  = (state_reg == RUN);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign acc       = acc_reg;
  assign ovf       = ovf_reg;

endmodule : mac2x2_accumulator

// File: tb/tb_mac2x2_accumulator.sv
// Self-checking bench: two instances (ACC_W=8 and ACC_W=4) share all inputs;
// expectations come from a true-sum model clamped to each width.
module tb_mac2x2_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       out_ready;

  logic       in_ready8, out_valid8, busy8, ovf8;
  logic [7:0] acc8;
  logic       in_ready4, out_valid4, busy4, ovf4;
  logic [3:0] acc4;

  int n_checks = 0;
  int n_fail   = 0;
  int model_sum = 0;
  int job_a[16];
  int job_b[16];

  typedef struct {
    int         n;
    logic [7:0] av;
    logic [7:0] bv;
    int         gap;
    int         hold;
    bit         poke;
    bit         pre_rst;
    int         e_acc8;
    int         e_acc4;
    int         e_ovf4;
  } vec_t;

  vec_t vecs[8];

  mac2x2_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .a(a), .b(b), .in_ready(in_ready8), .acc(acc8), .out_valid(out_valid8),
    .out_ready(out_ready), .busy(busy8), .ovf(ovf8)
  );

  mac2x2_accumulator #(.ACC_W(4), .LEN_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .a(a), .b(b), .in_ready(in_ready4), .acc(acc4), .out_valid(out_valid4),
    .out_ready(out_ready), .busy(busy4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare both instances against the model: acc is the true sum clamped
  // to the width, ovf is whether the true sum ever exceeded that width.
  task automatic chk_outs(input string tag, input bit e_ir, input bit e_ov, input bit e_busy);
    int e8, e4;
    e8 = (model_sum > 255) ? 255 : model_sum;
    e4 = (model_sum > 15) ? 15 : model_sum;
    chk({tag, "/acc8"}, int'(acc8), e8);
    chk({tag, "/acc4"}, int'(acc4), e4);
    chk({tag, "/ovf8"}, int'(ovf8), (model_sum > 255) ? 1 : 0);
    chk({tag, "/ovf4"}, int'(ovf4), (model_sum > 15) ? 1 : 0);
    chk({tag, "/in_ready8"}, int'(in_ready8), int'(e_ir));
    chk({tag, "/in_ready4"}, int'(in_ready4), int'(e_ir));
    chk({tag, "/out_valid8"}, int'(out_valid8), int'(e_ov));
    chk({tag, "/out_valid4"}, int'(out_valid4), int'(e_ov));
    chk({tag, "/busy8"}, int'(busy8), int'(e_busy));
    chk({tag, "/busy4"}, int'(busy4), int'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one job from IDLE through the DONE handshake, checking every cycle.
  task automatic run_job(input int n, input int gap, input int hold, input bit poke,
                         output int f8, output int f4, output int fo4);
    chk_outs("idle", 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    len   = 4'(n);
    step();
    start = 1'b0;
    model_sum = 0;
    if (n == 0) chk_outs("zero_len", 1'b0, 1'b1, 1'b1);
    else        chk_outs("run_entry", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        a     = 2'($urandom_range(3));
        b     = 2'($urandom_range(3));
        start = poke;
        len   = 4'($urandom_range(15));
        step();
        chk_outs("bubble", 1'b1, 1'b0, 1'b1);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      a        = 2'(job_a[i]);
      b        = 2'(job_b[i]);
      step();
      in_valid  = 1'b0;
      model_sum = model_sum + job_a[i] * job_b[i];
      if (i == n - 1) chk_outs("last_xfer", 1'b0, 1'b1, 1'b1);
      else            chk_outs("xfer", 1'b1, 1'b0, 1'b1);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = poke;
      step();
      chk_outs("hold", 1'b0, 1'b1, 1'b1);
    end
    f8  = int'(acc8);
    f4  = int'(acc4);
    fo4 = int'(ovf4);
    out_ready = 1'b1;
    start     = poke;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk_outs("handshake", 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("post_idle", 1'b0, 1'b0, 1'b0);
    $display("job n=%0d gap=%0d hold=%0d poke=%0d sum=%0d acc8=%0d acc4=%0d ovf4=%0d",
             n, gap, hold, poke, model_sum, f8, f4, fo4);
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] av, input logic [7:0] bv,
                              input int gap, input int hold, input bit poke, input bit pre_rst,
                              input int e8, input int e4, input int eo4);
    vec_t v;
    v.n = n; v.av = av; v.bv = bv; v.gap = gap; v.hold = hold; v.poke = poke;
    v.pre_rst = pre_rst; v.e_acc8 = e8; v.e_acc4 = e4; v.e_ovf4 = eo4;
    return v;
  endfunction

  initial begin
    int f8, f4, fo4, n;
    logic [7:0] pa, pb;

    // Operand pairs packed as {p3, p2, p1, p0}, 2 bits each.
    vecs[0] = mk(3, {2'd0, 2'd1, 2'd2, 2'd3}, {2'd0, 2'd1, 2'd3, 2'd3}, 0, 0, 0, 0, 16, 15, 1);
    vecs[1] = mk(0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0);
    vecs[2] = mk(2, {2'd0, 2'd0, 2'd3, 2'd3}, {2'd0, 2'd0, 2'd3, 2'd3}, 0, 0, 0, 0, 18, 15, 1);
    vecs[3] = mk(1, {2'd0, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd0, 2'd1}, 0, 0, 0, 0, 1, 1, 0);
    vecs[4] = mk(2, {2'd0, 2'd0, 2'd3, 2'd2}, {2'd0, 2'd0, 2'd2, 2'd1}, 2, 5, 0, 0, 8, 8, 0);
    vecs[5] = mk(3, {2'd0, 2'd3, 2'd2, 2'd1}, {2'd0, 2'd1, 2'd2, 2'd2}, 1, 2, 1, 0, 9, 9, 0);
    vecs[6] = mk(4, {2'd0, 2'd2, 2'd1, 2'd3}, {2'd3, 2'd2, 2'd3, 2'd2}, 0, 1, 0, 0, 13, 13, 0);
    vecs[7] = mk(1, {2'd0, 2'd0, 2'd0, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd2}, 0, 0, 0, 1, 4, 4, 0);

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    @(negedge clk);
    model_sum = 0;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_rst) begin
        // Abort a 4-term job after one transfer with an asynchronous reset.
        start = 1'b1; len = 4'd4;
        step();
        start = 1'b0; in_valid = 1'b1; a = 2'd3; b = 2'd3;
        step();
        in_valid  = 1'b0;
        model_sum = 9;
        chk_outs("pre_rst", 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 model_sum = 0;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk_outs("after_rst", 1'b0, 1'b0, 1'b0);
      end
      pa = vecs[i].av;
      pb = vecs[i].bv;
      for (int k = 0; k < 4; k++) begin
        job_a[k] = int'(pa[2*k +: 2]);
        job_b[k] = int'(pb[2*k +: 2]);
      end
      run_job(vecs[i].n, vecs[i].gap, vecs[i].hold, vecs[i].poke, f8, f4, fo4);
      chk("tbl_acc8", f8, vecs[i].e_acc8);
      chk("tbl_acc4", f4, vecs[i].e_acc4);
      chk("tbl_ovf4", fo4, vecs[i].e_ovf4);
    end

    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) begin
        job_a[k] = $urandom_range(0, 3);
        job_b[k] = $urandom_range(0, 3);
      end
      run_job(n, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              f8, f4, fo4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mac2x2_accumulator

// File: doc/mac2x2_accumulator.md
MAC2X2_ACCUMULATOR -- requirements
Module: mac2x2_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 8: accumulator width, legal range 4..16.
REQ-002 SHALL have parameter LEN_W, default 4: term-count width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests a new job; acted on only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: number of product terms; sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-008 SHALL have port a, input, 2 bits: operand A, unsigned.
REQ-009 SHALL have port b, input, 2 bits: operand B, unsigned.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts an operand pair.
REQ-011 SHALL have port acc, output, ACC_W bits: running or final sum of products.
REQ-012 SHALL have port out_valid, output, 1 bit: acc holds the final result.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN or DONE.
REQ-015 SHALL have port ovf, output, 1 bit: sticky saturation flag for the current job.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 In IDLE, in_ready, out_valid and busy SHALL be 0; in_valid SHALL be ignored.
REQ-018 In IDLE with start=1 and len!=0, the block SHALL clear acc and ovf, load remaining=len, and enter RUN on the same edge.
REQ-019 In IDLE with start=1 and len=0, the block SHALL clear acc and ovf and enter DONE directly.
REQ-020 In RUN, in_ready SHALL be 1; a transfer occurs on any edge where in_valid=1 and in_ready=1.
REQ-021 On each transfer, the block SHALL update acc to sat(acc + a*b) on that edge and decrement remaining.
REQ-022 The product SHALL be 4 bits wide (maximum 9) and zero-extended to ACC_W before the add.
REQ-023 If the true sum exceeds 2^ACC_W-1, acc SHALL be set to all ones and ovf to 1; ovf stays set until the next accepted start or reset.
REQ-024 Cycles in RUN with in_valid=0 SHALL leave acc and remaining unchanged.
REQ-025 The transfer that brings remaining to 0 SHALL move the FSM to DONE, so out_valid rises in the cycle immediately after the last transfer (latency 1).
REQ-026 In DONE, out_valid SHALL be 1 and acc SHALL be held stable until the first cycle with out_ready=1; the FSM then returns to IDLE on that edge.
REQ-027 start asserted in RUN or DONE SHALL be ignored; it is not queued.
REQ-028 The block SHALL not accept a new job in the same cycle as the DONE handshake; start is first honoured one cycle after the return to IDLE.

Reset
REQ-029 rst=1 SHALL immediately and asynchronously force state IDLE, acc=0, remaining=0, ovf=0, out_valid=0, in_ready=0, busy=0, regardless of the current state.
REQ-030 After rst deasserts, the first start SHALL behave exactly as it would from power-up.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the constant PROD_W=4.
REQ-032 The product SHALL come from a single instance of the existing multiplier2x2 sub-module (ports a, b, c); no other sub-modules.
REQ-033 All outputs SHALL be driven from registers or from the FSM state only, with no combinational path from in_valid to out_valid.

Verification
REQ-034 Basic job: len=3, back-to-back pairs (3,3),(2,3),(1,1) -> acc reads 9, 15, 16 after each transfer; out_valid=1 on the next cycle with acc=16, ovf=0.
REQ-035 Zero length: start with len=0 -> out_valid=1 the next cycle, acc=0; FSM returns to IDLE on out_ready=1.
REQ-036 Saturation: ACC_W=4, len=2, pairs (3,3),(3,3) -> acc=15, ovf=1; a following job with pair (1,1) -> acc=1, ovf=0.
REQ-037 Bubbles and backpressure: len=2 with in_valid low for 2 cycles between pairs -> acc changes only on transfer edges; out_ready held low for 5 cycles -> out_valid=1 and acc constant throughout.
REQ-038 Mid-operation reset: rst pulsed after 1 of 4 transfers -> all outputs 0 without waiting for a clock edge; a new start with len=1 and pair (2,2) -> acc=4.
REQ-039 Ignored start: start pulsed during RUN and during DONE -> remaining and acc are unaffected and exactly one out_valid handshake occurs.
